// File: rtl/dram_bank_sched_fsm.sv
// dram_bank_sched_fsm: one-request-at-a-time DRAM command sequencer.
// Tracks the open row of every bank and issues ACT/RD/WR/PRE/PREA/REF over a
// req/ack command handshake. Refresh is folded in only when the FSM is idle.
// Optional build macro CLOSED_PAGE_EN: every burst is followed by a PRE of
// its bank, so no row stays open between requests.
// NUMBER_OF_BANKS and NUMBER_OF_COLS are expected to be powers of two; column
// wrap-around relies on the natural CW-bit overflow.
module dram_bank_sched_fsm #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int BURST_LEN       = 4,
  localparam int BW = $clog2(NUMBER_OF_BANKS),
  localparam int RW = $clog2(NUMBER_OF_ROWS),
  localparam int CW = $clog2(NUMBER_OF_COLS)
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic                       req_we,
  input  logic [BW-1:0]              bank_id,
  input  logic [RW-1:0]              row_id,
  input  logic [CW-1:0]              col_id,
  input  logic                       refresh_flag,
  output logic                       cmd_req,
  input  logic                       cmd_ack,
  output logic [2:0]                 cmd,
  output logic [BW-1:0]              cmd_bank,
  output logic [RW-1:0]              cmd_row,
  output logic [CW-1:0]              cmd_col,
  output logic                       burst_done,
  output logic                       refresh_done,
  output logic [NUMBER_OF_BANKS-1:0] open_mask
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'b000,
    CMD_ACT  = 3'b001,
    CMD_RD   = 3'b010,
    CMD_WR   = 3'b011,
    CMD_PRE  = 3'b100,
    CMD_PREA = 3'b101,
    CMD_REF  = 3'b110
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_ACT, S_COL, S_PREA, S_REF
  } state_e;

`ifdef CLOSED_PAGE_EN
  localparam bit CLOSED_PAGE = 1'b1;
`else
  localparam bit CLOSED_PAGE = 1'b0;
`endif

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_e                     state_q, state_d;
  logic [BW-1:0]              req_bank_q, req_bank_d;
  logic [RW-1:0]              req_row_q, req_row_d;
  logic [CW-1:0]              req_col_q, req_col_d;
  logic                       req_we_q, req_we_d;
  logic                       pend_q, pend_d;       // request accepted alongside a refresh
  logic                       closing_q, closing_d; // PRE that ends a closed-page burst
  logic [CW-1:0]              beat_q, beat_d;
  logic [NUMBER_OF_BANKS-1:0] open_mask_q, open_mask_d;
  logic [RW-1:0]              open_row_q [NUMBER_OF_BANKS];
  logic                       row_we;

  logic                       req_rdy_q, req_rdy_d;
  logic                       cmd_req_q, cmd_req_d;
  cmd_e                       cmd_q, cmd_d;
  logic [BW-1:0]              cmd_bank_q, cmd_bank_d;
  logic [RW-1:0]              cmd_row_q, cmd_row_d;
  logic [CW-1:0]              cmd_col_q, cmd_col_d;
  logic                       burst_done_q, burst_done_d;
  logic                       refresh_done_q, refresh_done_d;

  logic accept, acked, refresh_go, row_hit;

  assign accept     = req_val && req_rdy_q;
  assign acked      = cmd_req_q && cmd_ack;
  // The cycle that shows refresh_done may still see the old refresh_flag level.
  assign refresh_go = refresh_flag && !refresh_done_q;
  assign row_hit    = open_mask_q[req_bank_q] && (open_row_q[req_bank_q] == req_row_q);

  // Next-state, bank-tracking and registered-output computation.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which keeps this block free of inferred latches.
    state_d        = state_q;
    req_bank_d     = req_bank_q;
    req_row_d      = req_row_q;
    req_col_d      = req_col_q;
    req_we_d       = req_we_q;
    pend_d         = pend_q;
    closing_d      = closing_q;
    beat_d         = beat_q;
    open_mask_d    = open_mask_q;
    row_we         = 1'b0;
    burst_done_d   = 1'b0;
    refresh_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (accept) begin
          req_bank_d = bank_id;
          req_row_d  = row_id;
          req_col_d  = col_id;
          req_we_d   = req_we;
        end
        if (refresh_go) begin
          pend_d  = pend_q || accept;
          state_d = (open_mask_q != '0) ? S_PREA : S_REF;
        end else if (accept || pend_q) begin
          pend_d  = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        beat_d    = '0;
        closing_d = 1'b0;
        if (!open_mask_q[req_bank_q]) state_d = S_ACT;
        else if (row_hit)             state_d = S_COL;
        else                          state_d = S_PRE;
      end
      S_PRE: begin
        if (acked) begin
          open_mask_d[req_bank_q] = 1'b0;
          if (closing_q) begin
            closing_d    = 1'b0;
            burst_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ACT;
          end
        end
      end
      S_ACT: begin
        if (acked) begin
          open_mask_d[req_bank_q] = 1'b1;
          row_we  = 1'b1;
          beat_d  = '0;
          state_d = S_COL;
        end
      end
      S_COL: begin
        if (acked) begin
          if (beat_q == LAST_BEAT) begin
            if (CLOSED_PAGE) begin
              closing_d = 1'b1;
              state_d   = S_PRE;
            end else begin
              burst_done_d = 1'b1;
              state_d      = S_IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_PREA: begin
        if (acked) begin
          open_mask_d = '0;
          state_d     = S_REF;
        end
      end
      S_REF: begin
        if (acked) begin
          refresh_done_d = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are a function of where the FSM is going, so they are valid
    // from the first cycle of each state and hold while the ack is pending.
    cmd_req_d = 1'b1;
    cmd_d     = CMD_NOP;
    unique case (state_d)
      S_PRE:   cmd_d = CMD_PRE;
      S_ACT:   cmd_d = CMD_ACT;
      S_COL:   cmd_d = req_we_d ? CMD_WR : CMD_RD;
      S_PREA:  cmd_d = CMD_PREA;
      S_REF:   cmd_d = CMD_REF;
      default: cmd_req_d = 1'b0;
    endcase
    cmd_bank_d = req_bank_d;
    cmd_row_d  = req_row_d;
    cmd_col_d  = req_col_d + beat_d;
    req_rdy_d  = (state_d == S_IDLE) && !pend_d && (!refresh_flag || refresh_done_d);
  end

  // FSM state, request latch, bank open mask and registered outputs.
  always_ff @(posedge clk or posedge rst_b) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_b) begin
      state_q        <= S_IDLE;
      req_bank_q     <= '0;
      req_row_q      <= '0;
      req_col_q      <= '0;
      req_we_q       <= 1'b0;
      pend_q         <= 1'b0;
      closing_q      <= 1'b0;
      beat_q         <= '0;
      open_mask_q    <= '0;
      req_rdy_q      <= 1'b0;
      cmd_req_q      <= 1'b0;
      cmd_q          <= CMD_NOP;
      cmd_bank_q     <= '0;
      cmd_row_q      <= '0;
      cmd_col_q      <= '0;
      burst_done_q   <= 1'b0;
      refresh_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_bank_q     <= req_bank_d;
      req_row_q      <= req_row_d;
      req_col_q      <= req_col_d;
      req_we_q       <= req_we_d;
      pend_q         <= pend_d;
      closing_q      <= closing_d;
      beat_q         <= beat_d;
      open_mask_q    <= open_mask_d;
      req_rdy_q      <= req_rdy_d;
      cmd_req_q      <= cmd_req_d;
      cmd_q          <= cmd_d;
      cmd_bank_q     <= cmd_bank_d;
      cmd_row_q      <= cmd_row_d;
      cmd_col_q      <= cmd_col_d;
      burst_done_q   <= burst_done_d;
      refresh_done_q <= refresh_done_d;
    end
  end

  // Open-row storage, written when an ACT is acked.
  always_ff @(posedge clk) begin
    // NOTE: the row array is deliberately not reset; an entry is only read
    // when its open_mask bit is set, and that mask is reset.
    if (row_we) open_row_q[req_bank_q] <= req_row_q;
  end

  assign req_rdy      = req_rdy_q;
  assign cmd_req      = cmd_req_q;
  assign cmd          = cmd_q;
  assign cmd_bank     = cmd_bank_q;
  assign cmd_row      = cmd_row_q;
  assign cmd_col      = cmd_col_q;
  assign burst_done   = burst_done_q;
  assign refresh_done = refresh_done_q;
  assign open_mask    = open_mask_q;

endmodule

// File: tb/tb_dram_bank_sched_fsm.sv
// Testbench for dram_bank_sched_fsm: randomized requests and refreshes
// checked against a bank-level reference model of the expected command
// stream. Honours CLOSED_PAGE_EN in the model when the build defines it.
module tb_dram_bank_sched_fsm;

  localparam int NB = 8;
  localparam int NR = 128;
  localparam int NC = 8;
  localparam int BL = 4;

`ifdef CLOSED_PAGE_EN
  localparam bit CLOSED_PAGE = 1'b1;
`else
  localparam bit CLOSED_PAGE = 1'b0;
`endif

  localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6;

  logic          clk = 1'b0;
  logic          rst_b, req_val, req_rdy, req_we, refresh_flag;
  logic [2:0]    bank_id, col_id, cmd, cmd_bank, cmd_col;
  logic [6:0]    row_id, cmd_row;
  logic          cmd_req, cmd_ack, burst_done, refresh_done;
  logic [NB-1:0] open_mask;

  dram_bank_sched_fsm #(
    .NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR),
    .NUMBER_OF_COLS(NC), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_b(rst_b), .req_val(req_val), .req_rdy(req_rdy),
    .req_we(req_we), .bank_id(bank_id), .row_id(row_id), .col_id(col_id),
    .refresh_flag(refresh_flag), .cmd_req(cmd_req), .cmd_ack(cmd_ack),
    .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .burst_done(burst_done), .refresh_done(refresh_done), .open_mask(open_mask)
  );

  always #5 clk = ~clk;

  // One expected command; pulse 1 = burst_done, 2 = refresh_done follows its ack.
  typedef struct {
    logic [2:0]    cmd;
    int            bank;
    int            row;
    int            col;
    int            pulse;
    logic [NB-1:0] mask;
  } exp_t;

  exp_t          exp_q[$];
  logic [NB-1:0] m_open;
  int            m_row[NB];
  int            tests = 0;
  int            fails = 0;
  int            acc_cyc, first_cyc;

  task automatic push_exp(input logic [2:0] c, input int b, input int r, input int col, input int p);
    exp_t e;
    e.cmd = c; e.bank = b; e.row = r; e.col = col; e.pulse = p; e.mask = m_open;
    exp_q.push_back(e);
  endtask

  // Reference model: what a request must produce, given which rows are open.
  task automatic model_request(input bit we, input int b, input int r, input int c);
    if (!(m_open[b] && m_row[b] == r)) begin
      if (m_open[b]) begin
        m_open[b] = 1'b0;
        push_exp(C_PRE, b, 0, 0, 0);
      end
      m_open[b] = 1'b1;
      m_row[b]  = r;
      push_exp(C_ACT, b, r, 0, 0);
    end
    for (int k = 0; k < BL; k++)
      push_exp(we ? C_WR : C_RD, b, r, (c + k) % NC, (!CLOSED_PAGE && k == BL - 1) ? 1 : 0);
    if (CLOSED_PAGE) begin
      m_open[b] = 1'b0;
      push_exp(C_PRE, b, 0, 0, 1);
    end
  endtask

  task automatic model_refresh();
    if (m_open != '0) begin
      m_open = '0;
      push_exp(C_PREA, 0, 0, 0, 0);
    end
    push_exp(C_REF, 0, 0, 0, 2);
  endtask

  task automatic drive_req(input bit we, input int b, input int r, input int c);
    req_val = 1'b1;
    req_we  = we;
    bank_id = 3'(b);
    row_id  = 7'(r);
    col_id  = 3'(c);
  endtask

  // Acks DUT commands (with optional stalls) and checks them against exp_q.
  // Must be called right after a falling edge.
  task automatic run_engine(input int stall_pct, input int hold_idx, input int hold_len);
    int   cyc = 0, n = 0, held = 0, pend_pulse = 0;
    bit   will_acc = 1'b0, chk_mask = 1'b0, ack, ok;
    logic [NB-1:0] exp_mask = '0;
    exp_t h;
    acc_cyc = -1;
    first_cyc = -1;
    while ((exp_q.size() > 0 || pend_pulse != 0) && cyc < 600) begin
      if (will_acc) req_val = 1'b0;
      will_acc = req_val && req_rdy;
      if (will_acc) acc_cyc = cyc;
      tests++;
      if (burst_done !== (pend_pulse == 1)) begin
        fails++;
        $display("FAIL burst_done @%0d: got %b want %b", cyc, burst_done, pend_pulse == 1);
      end
      tests++;
      if (refresh_done !== (pend_pulse == 2)) begin
        fails++;
        $display("FAIL refresh_done @%0d: got %b want %b", cyc, refresh_done, pend_pulse == 2);
      end
      if (pend_pulse == 2) refresh_flag = 1'b0;
      if (chk_mask) begin
        tests++;
        if (open_mask !== exp_mask) begin
          fails++;
          $display("FAIL open_mask @%0d: got %h want %h", cyc, open_mask, exp_mask);
        end
        chk_mask = 1'b0;
      end
      if (pend_pulse != 0 && exp_q.size() == 0) begin
        tests++;
        if (cmd_req !== 1'b0) begin
          fails++;
          $display("FAIL idle_after_done: got cmd_req=%b cmd=%0d want cmd_req=0", cmd_req, cmd);
        end
      end
      pend_pulse = 0;
      ack = 1'b0;
      if (cmd_req === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_cmd: got cmd=%0d col=%0d want none", cmd, cmd_col);
        end else begin
          h  = exp_q[0];
          ok = (cmd === h.cmd);
          if (h.cmd inside {C_ACT, C_PRE, C_RD, C_WR}) ok = ok && (cmd_bank === 3'(h.bank));
          if (h.cmd == C_ACT) ok = ok && (cmd_row === 7'(h.row));
          if (h.cmd inside {C_RD, C_WR}) ok = ok && (cmd_col === 3'(h.col));
          if (!ok) begin
            fails++;
            $display("FAIL cmd[%0d]: got cmd=%0d bank=%0d row=%0d col=%0d want cmd=%0d bank=%0d row=%0d col=%0d",
                     n, cmd, cmd_bank, cmd_row, cmd_col, h.cmd, h.bank, h.row, h.col);
          end
          if (h.cmd == C_PREA || h.cmd == C_REF) begin
            tests++;
            if (req_rdy !== 1'b0) begin
              fails++;
              $display("FAIL req_rdy_in_refresh: got %b want 0", req_rdy);
            end
          end
          if (n == hold_idx && held < hold_len) held++;
          else ack = ($urandom_range(99) >= stall_pct);
          if (ack) begin
            void'(exp_q.pop_front());
            n++;
            pend_pulse = h.pulse;
            exp_mask   = h.mask;
            chk_mask   = 1'b1;
          end
        end
      end
      cmd_ack = ack;
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0 || pend_pulse != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d commands outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    cmd_ack = 1'b0;
    req_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b1; req_val = 1'b0; req_we = 1'b0; bank_id = '0; row_id = '0;
    col_id = '0; refresh_flag = 1'b0; cmd_ack = 1'b0;
    m_open = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_rdy, cmd_req, cmd, cmd_bank, cmd_row, cmd_col, burst_done, refresh_done, open_mask} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b req=%b cmd=%0d mask=%h want all 0",
               req_rdy, cmd_req, cmd, open_mask);
    end
    rst_b = 1'b0;
    @(negedge clk);
    tests++;
    if (req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL rdy_after_reset: got %b want 1", req_rdy);
    end
  endtask

  task automatic test_empty();
    drive_req(1'b0, 2, 5, 6);
    model_request(1'b0, 2, 5, 6);
    run_engine(0, -1, 0);
    tests++;
    if (open_mask !== m_open) begin
      fails++;
      $display("FAIL empty_mask: got %h want %h", open_mask, m_open);
    end
  endtask

  task automatic test_hit();
    drive_req(1'b0, 2, 5, 6);
    model_request(1'b0, 2, 5, 6);
    run_engine(0, -1, 0);
    tests++;
    if (first_cyc < 0 || acc_cyc < 0 || first_cyc - acc_cyc > 2) begin
      fails++;
      $display("FAIL hit_latency: got %0d cycles want <= 2", first_cyc - acc_cyc);
    end
  endtask

  task automatic test_miss();
    drive_req(1'b1, 2, 9, 1);
    model_request(1'b1, 2, 9, 1);
    run_engine(0, -1, 0);
  endtask

  task automatic test_refresh();
    drive_req(1'b0, 3, 11, 2);
    model_request(1'b0, 3, 11, 2);
    run_engine(20, -1, 0);
    refresh_flag = 1'b1;
    drive_req(1'b0, 5, 4, 7);
    model_refresh();
    model_request(1'b0, 5, 4, 7);
    run_engine(0, -1, 0);
    tests++;
    if (refresh_flag !== 1'b0) begin
      fails++;
      $display("FAIL refresh_seen: got refresh_done never want pulse");
      refresh_flag = 1'b0;
    end
  endtask

  task automatic test_stall();
    drive_req(1'b1, 4, 7, 5);
    model_request(1'b1, 4, 7, 5);
    run_engine(0, exp_q.size() - BL + 1, 5);
  endtask

  task automatic test_reset_mid_act();
    bit seen = 1'b0;
    drive_req(1'b0, 6, 3, 0);
    cmd_ack = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      req_val = 1'b0;
      if (cmd_req === 1'b1 && cmd === C_ACT) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL act_before_reset: got cmd=%0d want ACT", cmd);
    end
    #2 rst_b = 1'b1;
    #1;
    tests++;
    if (cmd_req !== 1'b0 || open_mask !== '0) begin
      fails++;
      $display("FAIL async_reset: got cmd_req=%b mask=%h want 0 0", cmd_req, open_mask);
    end
    @(negedge clk);
    rst_b  = 1'b0;
    m_open = '0;
    exp_q.delete();
    @(negedge clk);
    drive_req(1'b1, 2, 9, 3);
    model_request(1'b1, 2, 9, 3);
    run_engine(0, -1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(4) == 0) begin
        refresh_flag = 1'b1;
        model_refresh();
      end else begin
        int b = $urandom_range(NB - 1);
        int r = $urandom_range(3);
        int c = $urandom_range(NC - 1);
        bit w = 1'($urandom_range(1));
        drive_req(w, b, r, c);
        model_request(w, b, r, c);
      end
      run_engine(30, -1, 0);
      refresh_flag = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_hit();
    test_miss();
    test_refresh();
    test_stall();
    test_reset_mid_act();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
